// File: rtl/hazard_track_pipe_pkg.sv
// Shared definitions for the E/M/W hazard tracking pipeline.
// Slot record layout, reset constants and the saturating Tnew step.
package hazard_track_pipe_pkg;

  localparam int unsigned TNEW_W   = 3;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned PC_W     = 32;
  localparam int unsigned A3_W     = 5;
  localparam logic [PC_W-1:0]    PC_RESET = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP      = 32'h0000_0000;

  typedef logic [TNEW_W-1:0] tnew_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [A3_W-1:0]    a3;
    tnew_t              tnew;
  } slot_t;

  // One stage hop of Tnew; holds at zero instead of wrapping.
  function automatic tnew_t tnew_dec(input tnew_t t);
    return (t == '0) ? '0 : t - tnew_t'(1);
  endfunction

endpackage

// File: rtl/hazard_track_pipe_stage_reg.sv
// Single pipeline slot register with synchronous clear and optional Tnew decrement.
module hazard_stage_reg
  import hazard_track_pipe_pkg::*;
#(
  parameter bit              DEC    = 1'b0,
  parameter logic [PC_W-1:0] RST_PC = PC_RESET
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  clr,
  input  slot_t d,
  output slot_t q
);

  // Reset and clear both leave an empty bubble in the slot.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '{valid: 1'b0, instr: NOP, pc: RST_PC, a3: '0, tnew: '0};
    end else begin
      q <= '{valid: d.valid,
             instr: d.instr,
             pc:    d.pc,
             a3:    d.a3,
             tnew:  DEC ? tnew_dec(d.tnew) : d.tnew};
    end
  end

endmodule

// File: rtl/hazard_track_pipe.sv
// E/M/W tracking pipeline: carries A3/Tnew/Instr/PC from D to W for the
// stall and forwarding units, plus stall and retire performance counters.
module hazard_track_pipe
  import hazard_track_pipe_pkg::slot_t;
  import hazard_track_pipe_pkg::tnew_t;
#(
  parameter int unsigned TNEW_W   = hazard_track_pipe_pkg::TNEW_W,
  parameter logic [31:0] PC_RESET = hazard_track_pipe_pkg::PC_RESET,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Instr_D,
  input  logic [31:0]       PC_D,
  input  logic [4:0]        A3_D,
  input  logic [TNEW_W-1:0] Tnew_D,
  input  logic              E_REG_clr,
  output logic [31:0]       Instr_E,
  output logic [31:0]       Instr_M,
  output logic [31:0]       Instr_W,
  output logic [31:0]       PC_E,
  output logic [31:0]       PC_M,
  output logic [31:0]       PC_W,
  output logic [4:0]        A3_E,
  output logic [4:0]        A3_M,
  output logic [4:0]        A3_W,
  output logic [TNEW_W-1:0] Tnew_E,
  output logic [TNEW_W-1:0] Tnew_M,
  output logic              ready_E,
  output logic              ready_M,
  output logic              wen_W,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  slot_t slot_d, slot_e, slot_m, slot_w;

  assign slot_d = '{valid: 1'b1, instr: Instr_D, pc: PC_D, a3: A3_D,
                    tnew: tnew_t'(Tnew_D)};

  hazard_stage_reg #(.DEC(1'b0), .RST_PC(PC_RESET)) u_stage_e (
    .clk(clk), .reset(reset), .clr(E_REG_clr), .d(slot_d), .q(slot_e));

  hazard_stage_reg #(.DEC(1'b1), .RST_PC(PC_RESET)) u_stage_m (
    .clk(clk), .reset(reset), .clr(1'b0), .d(slot_e), .q(slot_m));

  hazard_stage_reg #(.DEC(1'b1), .RST_PC(PC_RESET)) u_stage_w (
    .clk(clk), .reset(reset), .clr(1'b0), .d(slot_m), .q(slot_w));

  // A3 is masked on bubbles so the stall unit can never match an empty slot.
  assign Instr_E = slot_e.instr;
  assign Instr_M = slot_m.instr;
  assign Instr_W = slot_w.instr;
  assign PC_E    = slot_e.pc;
  assign PC_M    = slot_m.pc;
  assign PC_W    = slot_w.pc;
  assign A3_E    = slot_e.valid ? slot_e.a3 : 5'd0;
  assign A3_M    = slot_m.valid ? slot_m.a3 : 5'd0;
  assign A3_W    = slot_w.valid ? slot_w.a3 : 5'd0;
  assign Tnew_E  = TNEW_W'(slot_e.tnew);
  assign Tnew_M  = TNEW_W'(slot_m.tnew);
  assign ready_E = slot_e.valid && (slot_e.a3 != 5'd0) && (slot_e.tnew == '0);
  assign ready_M = slot_m.valid && (slot_m.a3 != 5'd0) && (slot_m.tnew == '0);
  assign wen_W   = slot_w.valid && (slot_w.a3 != 5'd0);

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (E_REG_clr && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (slot_w.valid && !(&retire_cnt))
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // A valid write-back slot must have its result available.
  a_tnew_w_zero : assert property (@(posedge clk) disable iff (reset)
                                   slot_w.valid |-> (slot_w.tnew == '0));

endmodule

// File: tb/tb_hazard_track_pipe.sv
// Self-checking bench for hazard_track_pipe: history-based model plus directed literals.
module tb_hazard_track_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_D, PC_D;
  logic [4:0]  A3_D;
  logic [2:0]  Tnew_D;
  logic        E_REG_clr;

  logic [31:0] Instr_E, Instr_M, Instr_W, PC_E, PC_M, PC_W;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic [2:0]  Tnew_E, Tnew_M;
  logic        ready_E, ready_M, wen_W;
  logic [31:0] stall_cnt, retire_cnt;

  logic [31:0] Instr_E4, Instr_M4, Instr_W4, PC_E4, PC_M4, PC_W4;
  logic [4:0]  A3_E4, A3_M4, A3_W4;
  logic [2:0]  Tnew_E4, Tnew_M4;
  logic        ready_E4, ready_M4, wen_W4;
  logic [3:0]  stall_cnt4, retire_cnt4;

  always #5 clk = ~clk;

  hazard_track_pipe dut (
    .clk(clk), .reset(reset), .Instr_D(Instr_D), .PC_D(PC_D), .A3_D(A3_D),
    .Tnew_D(Tnew_D), .E_REG_clr(E_REG_clr),
    .Instr_E(Instr_E), .Instr_M(Instr_M), .Instr_W(Instr_W),
    .PC_E(PC_E), .PC_M(PC_M), .PC_W(PC_W),
    .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
    .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
    .ready_E(ready_E), .ready_M(ready_M), .wen_W(wen_W),
    .stall_cnt(stall_cnt), .retire_cnt(retire_cnt));

  hazard_track_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .Instr_D(Instr_D), .PC_D(PC_D), .A3_D(A3_D),
    .Tnew_D(Tnew_D), .E_REG_clr(E_REG_clr),
    .Instr_E(Instr_E4), .Instr_M(Instr_M4), .Instr_W(Instr_W4),
    .PC_E(PC_E4), .PC_M(PC_M4), .PC_W(PC_W4),
    .A3_E(A3_E4), .A3_M(A3_M4), .A3_W(A3_W4),
    .Tnew_E(Tnew_E4), .Tnew_M(Tnew_M4),
    .ready_E(ready_E4), .ready_M(ready_M4), .wen_W(wen_W4),
    .stall_cnt(stall_cnt4), .retire_cnt(retire_cnt4));

  typedef struct {
    bit          v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  a3;
    int          tnew;
  } rec_t;

  // hist[k] is whatever entered E k+1 edges ago; it now sits in stage k (E, M, W).
  rec_t    hist [3];
  longint  m_stall, m_retire, m_stall4, m_retire4;
  bit      model_ok = 1'b0;
  int      checks = 0;
  int      errors = 0;

  function automatic rec_t bubble();
    rec_t r;
    r.v = 1'b0; r.instr = 32'h0; r.pc = 32'h3000; r.a3 = 5'd0; r.tnew = 0;
    return r;
  endfunction

  function automatic rec_t age(input rec_t h, input int k);
    rec_t r = h;
    r.tnew = (h.tnew > k) ? h.tnew - k : 0;
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic cyc(input bit r, input bit c, input logic [4:0] a3, input int t,
                     input logic [31:0] instr, input logic [31:0] pc);
    rec_t n;
    reset = r; E_REG_clr = c; A3_D = a3; Tnew_D = 3'(t); Instr_D = instr; PC_D = pc;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) hist[i] = bubble();
      m_stall = 0; m_retire = 0; m_stall4 = 0; m_retire4 = 0;
      model_ok = 1'b1;
    end else begin
      if (hist[2].v) begin
        if (m_retire < 64'hFFFF_FFFF) m_retire++;
        if (m_retire4 < 15) m_retire4++;
      end
      if (c) begin
        if (m_stall < 64'hFFFF_FFFF) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      n.v = 1'b1; n.instr = instr; n.pc = pc; n.a3 = a3; n.tnew = t;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = c ? bubble() : n;
    end
    @(negedge clk);
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    rec_t e, m, w;
    if (model_ok) begin
      e = hist[0];
      m = age(hist[1], 1);
      w = age(hist[2], 2);
      chk("Instr_E", Instr_E, e.instr);
      chk("Instr_M", Instr_M, m.instr);
      chk("Instr_W", Instr_W, w.instr);
      chk("PC_E", PC_E, e.pc);
      chk("PC_M", PC_M, m.pc);
      chk("PC_W", PC_W, w.pc);
      chk("A3_E", 32'(A3_E), e.v ? 32'(e.a3) : 32'd0);
      chk("A3_M", 32'(A3_M), m.v ? 32'(m.a3) : 32'd0);
      chk("A3_W", 32'(A3_W), w.v ? 32'(w.a3) : 32'd0);
      chk("Tnew_E", 32'(Tnew_E), 32'(e.tnew));
      chk("Tnew_M", 32'(Tnew_M), 32'(m.tnew));
      chk("ready_E", 32'(ready_E), 32'(e.v && e.a3 != 0 && e.tnew == 0));
      chk("ready_M", 32'(ready_M), 32'(m.v && m.a3 != 0 && m.tnew == 0));
      chk("wen_W", 32'(wen_W), 32'(w.v && w.a3 != 0));
      chk("stall_cnt", stall_cnt, 32'(m_stall));
      chk("retire_cnt", retire_cnt, 32'(m_retire));
      chk("stall_cnt4", 32'(stall_cnt4), 32'(m_stall4));
      chk("retire_cnt4", 32'(retire_cnt4), 32'(m_retire4));
      chk("A3_W4", 32'(A3_W4), w.v ? 32'(w.a3) : 32'd0);
    end
  end

  initial begin
    reset = 1'b1; E_REG_clr = 1'b0; A3_D = '0; Tnew_D = '0; Instr_D = '0; PC_D = '0;
    for (int i = 0; i < 3; i++) hist[i] = bubble();
    m_stall = 0; m_retire = 0; m_stall4 = 0; m_retire4 = 0;
    @(negedge clk);

    // Reset held two cycles
    cyc(1, 0, 5'd7, 1, 32'hdead_beef, 32'h1234);
    cyc(1, 0, 5'd7, 1, 32'hdead_beef, 32'h1234);
    chk("rst Instr_E", Instr_E, 32'h0);
    chk("rst PC_W", PC_W, 32'h3000);
    chk("rst A3_M", 32'(A3_M), 32'd0);
    chk("rst wen_W", 32'(wen_W), 32'd0);
    chk("rst stall", stall_cnt, 32'd0);
    chk("rst retire", retire_cnt, 32'd0);

    // lw $8 flowing E -> M -> W
    cyc(0, 0, 5'd8, 2, 32'h8c08_0000, 32'h3004);
    chk("lw A3_E", 32'(A3_E), 32'd8);
    chk("lw Tnew_E", 32'(Tnew_E), 32'd2);
    chk("lw ready_E", 32'(ready_E), 32'd0);
    cyc(0, 0, 5'd0, 0, 32'h0, 32'h3008);
    chk("lw A3_M", 32'(A3_M), 32'd8);
    chk("lw Tnew_M", 32'(Tnew_M), 32'd1);
    chk("lw ready_M", 32'(ready_M), 32'd0);
    cyc(0, 0, 5'd0, 0, 32'h0, 32'h300c);
    chk("lw A3_W", 32'(A3_W), 32'd8);
    chk("lw wen_W", 32'(wen_W), 32'd1);
    chk("lw PC_W", PC_W, 32'h3004);
    cyc(0, 0, 5'd0, 0, 32'h0, 32'h3010);
    chk("lw retire", retire_cnt, 32'd1);

    // Two bubbles, then the held instruction enters E
    cyc(0, 1, 5'd9, 1, 32'h3409_0001, 32'h3014);
    chk("clr1 A3_E", 32'(A3_E), 32'd0);
    chk("clr1 Instr_E", Instr_E, 32'h0);
    cyc(0, 1, 5'd9, 1, 32'h3409_0001, 32'h3014);
    chk("clr2 A3_E", 32'(A3_E), 32'd0);
    chk("clr2 Instr_E", Instr_E, 32'h0);
    chk("clr2 stall", stall_cnt, 32'd2);
    cyc(0, 0, 5'd9, 1, 32'h3409_0001, 32'h3014);
    chk("clr3 A3_E", 32'(A3_E), 32'd9);
    chk("clr3 PC_E", PC_E, 32'h3014);

    // ori (Tnew 1), jal (Tnew 0), then A3=0 with nonzero Tnew
    cyc(0, 0, 5'd10, 1, 32'h340a_0003, 32'h3018);
    chk("ori Tnew_E", 32'(Tnew_E), 32'd1);
    chk("ori ready_E", 32'(ready_E), 32'd0);
    cyc(0, 0, 5'd31, 0, 32'h0c00_0c10, 32'h301c);
    chk("ori Tnew_M", 32'(Tnew_M), 32'd0);
    chk("ori ready_M", 32'(ready_M), 32'd1);
    chk("jal ready_E", 32'(ready_E), 32'd1);
    cyc(0, 0, 5'd0, 2, 32'h1000_0004, 32'h3020);
    chk("jal Tnew_M", 32'(Tnew_M), 32'd0);
    chk("jal ready_M", 32'(ready_M), 32'd1);
    chk("a3z ready_E", 32'(ready_E), 32'd0);
    chk("a3z Tnew_E", 32'(Tnew_E), 32'd2);
    cyc(0, 0, 5'd0, 0, 32'h0, 32'h3024);
    chk("a3z Tnew_M", 32'(Tnew_M), 32'd1);
    chk("a3z ready_M", 32'(ready_M), 32'd0);
    cyc(0, 0, 5'd0, 0, 32'h0, 32'h3028);
    chk("a3z wen_W", 32'(wen_W), 32'd0);

    // Reset with all three stages full
    cyc(0, 0, 5'd1, 0, 32'h3401_0001, 32'h302c);
    cyc(0, 0, 5'd2, 0, 32'h3402_0002, 32'h3030);
    cyc(0, 0, 5'd3, 0, 32'h3403_0003, 32'h3034);
    chk("full A3_W", 32'(A3_W), 32'd1);
    cyc(1, 0, 5'd5, 0, 32'h3405_0005, 32'h3038);
    chk("mid rst A3_E", 32'(A3_E), 32'd0);
    chk("mid rst A3_M", 32'(A3_M), 32'd0);
    chk("mid rst A3_W", 32'(A3_W), 32'd0);
    chk("mid rst Instr_W", Instr_W, 32'h0);
    chk("mid rst stall", stall_cnt, 32'd0);
    chk("mid rst retire", retire_cnt, 32'd0);
    cyc(0, 0, 5'd4, 0, 32'h3404_0004, 32'h3040);
    chk("post A3_E", 32'(A3_E), 32'd4);
    cyc(0, 0, 5'd0, 0, 32'h0, 32'h3044);
    cyc(0, 0, 5'd0, 0, 32'h0, 32'h3048);
    chk("post A3_W", 32'(A3_W), 32'd4);
    chk("post wen_W", 32'(wen_W), 32'd1);

    // Long stall: 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++) cyc(0, 1, 5'd6, 1, 32'h3406_0006, 32'h304c);
    chk("sat stall4", 32'(stall_cnt4), 32'd15);
    chk("sat stall", stall_cnt, 32'd20);
    cyc(0, 0, 5'd6, 1, 32'h3406_0006, 32'h304c);
    chk("sat hold stall4", 32'(stall_cnt4), 32'd15);
    cyc(0, 0, 5'd0, 0, 32'h0, 32'h3050);
    cyc(0, 0, 5'd0, 0, 32'h0, 32'h3054);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
